stopwatch_ctrl: RTL

Controller that sequences two cascaded `sixtycount` mod-60 BCD counters (seconds, minutes) as a 00:00–59:59 stopwatch. It divides the system clock to a 1 s tick, runs a start/pause/clear/lap state machine from push-button levels, and drives the counters' enables and clear. It also presents a live or lap-frozen display value. It sits between the board buttons, the two counter instances and the display driver.

---
 rtl/stopwatch_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer for two cascaded mod-60 BCD counters: 1 s prescaler,
// start/pause/clear/lap button handling, counter enables and display freeze.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       btn_lap,
  input  logic       sec_co,
  input  logic       min_co,
  input  logic [7:0] sec_bcd,
  input  logic [7:0] min_bcd,
  output logic       sec_en,
  output logic       min_en,
  output logic       cnt_rst,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_min,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FULL} state_t;

  state_t      state;
  logic [PW-1:0] prescaler;
  logic        ss_prev, clr_prev, lap_prev;
  logic [7:0]  frz_sec, frz_min;
  logic        ss_edge, clr_edge, lap_edge, tick, saturated;

  always_comb begin
    ss_edge   = btn_ss  & ~ss_prev;
    clr_edge  = btn_clr & ~clr_prev;
    lap_edge  = btn_lap & ~lap_prev;
    tick      = (state == RUN) && (prescaler == LAST);
    saturated = tick && sec_co && min_co;
    sec_en    = tick && !(sec_co && min_co);
    min_en    = tick && sec_co && !min_co;
    running   = (state == RUN);
    disp_sec  = lap_active ? frz_sec : sec_bcd;
    disp_min  = lap_active ? frz_min : min_bcd;
  end

  // The prescaler advances in every RUN cycle, even one that also sees an
  // ss edge, so a pause keeps the partial second it has accumulated.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prescaler  <= '0;
      ss_prev    <= 1'b0;
      clr_prev   <= 1'b0;
      lap_prev   <= 1'b0;
      frz_sec    <= 8'h00;
      frz_min    <= 8'h00;
      cnt_rst    <= 1'b0;
      lap_active <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      ss_prev  <= btn_ss;
      clr_prev <= btn_clr;
      lap_prev <= btn_lap;
      cnt_rst  <= clr_edge;
      if (clr_edge) begin
        state      <= IDLE;
        prescaler  <= '0;
        lap_active <= 1'b0;
        ovf        <= 1'b0;
      end else begin
        if (state == RUN)
          prescaler <= tick ? '0 : prescaler + 1'b1;
        if (ss_edge) begin
          case (state)
            IDLE: begin
              state     <= RUN;
              prescaler <= '0;
            end
            RUN:     state <= PAUSE;
            PAUSE:   state <= RUN;
            default: state <= state;
          endcase
        end else if (saturated) begin
          state <= FULL;
          ovf   <= 1'b1;
        end
        if (lap_edge) begin
          if (lap_active)
            lap_active <= 1'b0;
          else if (state == RUN || state == PAUSE) begin
            lap_active <= 1'b1;
            frz_sec    <= sec_bcd;
            frz_min    <= min_bcd;
          end
        end
      end
    end
  end

endmodule
